reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised power-on and change-triggered reset generator; next generation of the fixed 12-input delay/reset block used by the room-management front end.
- Holds downstream logic in reset for a power-up interval.
- Afterwards issues a fixed-width reset pulse whenever any enabled room/case input changes, or on a forced request.
- Adds input synchronisation, per-channel masking, hold-off with retrigger coalescing, cause reporting and an event counter.

Parameters:
NUM_CH, 12, number of monitored case inputs (1..32)
POR_CYCLES, 1048575, power-up reset length in clock cycles (>=1)
PULSE_CYCLES, 16, width of each change-triggered reset pulse (>=1)
HOLDOFF_CYCLES, 1024, minimum released time between pulses (0 = hold-off skipped)
SYNC_STAGES, 2, synchroniser depth per channel (>=2)
FILTER_CYCLES, 4, stability window used only when the glitch filter is compiled in (>=1)

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iCASE  in  NUM_CH  monitored asynchronous case inputs
iMASK  in  NUM_CH  1 = channel enabled for triggering
iFORCE  in  1  synchronous single-cycle request for a pulse
oRESET  out  1  active-low reset to downstream logic (0 = held in reset)
oBUSY  out  1  high in POWERUP, PULSE and HOLDOFF
oCAUSE  out  NUM_CH  channels responsible for the current/last pulse
oEVT_CNT  out  8  saturating count of change-triggered pulses

Behaviour:
- iRST_N low, asynchronous: oRESET=0, oBUSY=1, oCAUSE=0, oEVT_CNT=0, sync chains=0, shadow=0, pending=0, counter=0, state=POWERUP.
- Each iCASE bit passes through SYNC_STAGES flops, giving syn[].
- change = (syn ^ shadow) & iMASK.
- Masked channels: shadow[i] follows syn[i] every cycle, so unmasking never fires on stale history.
- POWERUP: count 0..POR_CYCLES-1 with oRESET=0. On the last count: shadow<=syn, oRESET<=1, go IDLE. Values present at power-up never trigger a pulse.
- IDLE: if change!=0 or iFORCE, then next cycle:
  - oRESET=0
  - shadow<=syn
  - oCAUSE<=change
  - oEVT_CNT+1, saturating at 255
  - go PULSE
- Latency from an iCASE edge to oRESET low is SYNC_STAGES+1 cycles.
- PULSE: oRESET=0 for exactly PULSE_CYCLES cycles, then oRESET=1 and go HOLDOFF, or go IDLE if HOLDOFF_CYCLES=0.
- PULSE and HOLDOFF: new changes update shadow and OR into pending[]. An iFORCE sets pending_force. Neither extends the current pulse.
- HOLDOFF: oRESET=1 for HOLDOFF_CYCLES cycles, then:
  - if pending!=0 or pending_force: retrigger PULSE, oCAUSE<=pending, clear pending, oEVT_CNT+1.
  - otherwise go IDLE.
- With HOLDOFF_CYCLES=0, the pending check happens at the end of PULSE.
- Any number of changes within one PULSE+HOLDOFF window produce exactly one follow-up pulse.
- Simultaneous changes on several channels produce one pulse, with all their bits set in oCAUSE.
- Counter width is clog2 of max(POR_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES)+1. The counter is shared across states and cleared on every state entry.
- iRST_N asserted mid-operation aborts immediately to the reset values and restarts POWERUP.
- All outputs are registered.

Optional Feature:
RESET_SEQUENCER_GLITCH_FILTER_EN
- Defined: a channel counts as changed only after syn[i]!=shadow[i] for FILTER_CYCLES consecutive cycles. A per-channel counter clears whenever the difference disappears. Latency becomes SYNC_STAGES+FILTER_CYCLES+1.
- Undefined: no filter logic is generated, FILTER_CYCLES is ignored, and latency is SYNC_STAGES+1.

Decomposition:
- Package reset_sequencer_pkg holds:
  - state enum {POWERUP, IDLE, PULSE, HOLDOFF}
  - EVT_CNT_W=8
  - a max/clog2 width helper function
- One natural sub-module, rst_seq_chan, instantiated NUM_CH times. It contains the synchroniser, shadow bit, mask handling and the optional filter, and outputs a per-channel change flag.

Test Plan:
1. POR_CYCLES=100, iCASE=0x0A5 held from reset -> oRESET=0 for 100 cycles after iRST_N release, then 1; no pulse follows; oEVT_CNT=0.
2. In IDLE, toggle iCASE[3] -> oRESET low at cycle SYNC_STAGES+1 for exactly 16 cycles; oCAUSE=0x008; oEVT_CNT=1; oBUSY high through PULSE+HOLDOFF.
3. iMASK[7]=0, toggle iCASE[7], then set iMASK[7]=1 -> no pulse at any point.
4. Toggle ch0, then ch5 during PULSE, then ch9 during HOLDOFF -> first pulse oCAUSE=0x001; after 1024 released cycles a second pulse with oCAUSE=0x220; oEVT_CNT=2.
5. iFORCE for one cycle in IDLE -> one 16-cycle pulse with oCAUSE=0. Drop iRST_N during that pulse -> immediately oRESET=0, oEVT_CNT=0, POWERUP restarts.
6. 260 isolated toggles on ch1 -> oEVT_CNT stops at 255. With the macro defined, a 3-cycle glitch is ignored and a 5-cycle level triggers a pulse.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encoding, event counter width and counter sizing helper
package reset_sequencer_pkg;

    typedef enum logic [1:0] {POWERUP, IDLE, PULSE, HOLDOFF} seqState_t;

    localparam int EVT_CNT_W = 8;

    function automatic int cntWidth(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_chan.sv
// rst_seq_chan: one monitored input - synchroniser, shadow copy, masking and change flag
// Glitch filter is compiled in when RESET_SEQUENCER_GLITCH_FILTER_EN is defined.
module rst_seq_chan #(
    parameter int SYNC_STAGES = 2
`ifdef RESET_SEQUENCER_GLITCH_FILTER_EN
    , parameter int FILTER_CYCLES = 4
`endif
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iCase,
    input  logic iMask,
    input  logic iLoad,
    output logic oChange
);

    logic [SYNC_STAGES-1:0] syncChain;
    logic shadow;
    logic diff;

    assign diff = (syncChain[SYNC_STAGES-1] ^ shadow) & iMask;

    // Masked channels track the input so re-enabling never fires on old history
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            syncChain <= '0;
            shadow    <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], iCase};
            if (iLoad || oChange || !iMask) shadow <= syncChain[SYNC_STAGES-1];
        end
    end

`ifdef RESET_SEQUENCER_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    logic [FW-1:0] stableCnt;

    assign oChange = diff && (stableCnt == FW'(FILTER_CYCLES));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) stableCnt <= '0;
        else         stableCnt <= (diff && !oChange && !iLoad) ? stableCnt + FW'(1) : '0;
    end
`else
    assign oChange = diff;
`endif

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on reset followed by change/force triggered reset pulses with hold-off
// Optional per-channel glitch filter: define RESET_SEQUENCER_GLITCH_FILTER_EN.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_CH         = 12,
    parameter int POR_CYCLES     = 1048575,
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [NUM_CH-1:0]    iCASE,
    input  logic [NUM_CH-1:0]    iMASK,
    input  logic                 iFORCE,
    output logic                 oRESET,
    output logic                 oBUSY,
    output logic [NUM_CH-1:0]    oCAUSE,
    output logic [EVT_CNT_W-1:0] oEVT_CNT
);

    localparam int CW = cntWidth(POR_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES);

    if (NUM_CH < 1 || NUM_CH > 32 || POR_CYCLES < 1 || PULSE_CYCLES < 1 ||
        HOLDOFF_CYCLES < 0 || SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : gBadParams
        $error("reset_sequencer: illegal parameter set");
    end

    seqState_t state, stateNext;
    logic [CW-1:0] cnt;
    logic [NUM_CH-1:0] change, pending, pendNext;
    logic pendForce, forceNext, fire, load;

    for (genvar i = 0; i < NUM_CH; i++) begin : gChan
        rst_seq_chan #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef RESET_SEQUENCER_GLITCH_FILTER_EN
            , .FILTER_CYCLES(FILTER_CYCLES)
`endif
        ) uChan (
            .iCLK(iCLK),
            .iRST_N(iRST_N),
            .iCase(iCASE[i]),
            .iMask(iMASK[i]),
            .iLoad(load),
            .oChange(change[i])
        );
    end

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        fire      = 1'b0;
        pendNext  = pending | change;
        forceNext = pendForce | iFORCE;
        unique case (state)
            POWERUP: begin
                load      = cnt == CW'(POR_CYCLES - 1);
                stateNext = load ? IDLE : POWERUP;
            end
            IDLE: begin
                fire      = (|pendNext) || forceNext;
                stateNext = fire ? PULSE : IDLE;
            end
            PULSE:
                if (cnt == CW'(PULSE_CYCLES - 1)) stateNext = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            HOLDOFF:
                if (cnt == CW'(HOLDOFF_CYCLES - 1)) begin
                    fire      = (|pendNext) || forceNext;
                    stateNext = fire ? PULSE : IDLE;
                end
        endcase
    end

    // Counter restarts on every state entry, including a HOLDOFF->PULSE retrigger
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= POWERUP;
            cnt       <= '0;
            pending   <= '0;
            pendForce <= 1'b0;
            oRESET    <= 1'b0;
            oBUSY     <= 1'b1;
            oCAUSE    <= '0;
            oEVT_CNT  <= '0;
        end else begin
            state     <= stateNext;
            cnt       <= (stateNext != state || fire) ? '0 : cnt + CW'(1);
            pending   <= (fire || state == POWERUP) ? '0 : pendNext;
            pendForce <= (fire || state == POWERUP) ? 1'b0 : forceNext;
            oRESET    <= stateNext == IDLE || stateNext == HOLDOFF;
            oBUSY     <= stateNext != IDLE;
            if (fire) begin
                oCAUSE   <= pendNext;
                oEVT_CNT <= (&oEVT_CNT) ? oEVT_CNT : oEVT_CNT + EVT_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks of reset_sequencer against a timestamp model
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int NUM_CH = 12;
    localparam int POR    = 100;
    localparam int PULSE  = 16;
    localparam int HOLD   = 64;
    localparam int SYNC   = 2;
    localparam int FILT   = 4;

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;
    logic iFORCE = 1'b0;
    logic [NUM_CH-1:0] iCASE = 12'h0A5;
    logic [NUM_CH-1:0] iMASK = '1;
    logic oRESET, oBUSY;
    logic [NUM_CH-1:0] oCAUSE;
    logic [7:0] oEVT_CNT;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .NUM_CH(NUM_CH), .POR_CYCLES(POR), .PULSE_CYCLES(PULSE),
        .HOLDOFF_CYCLES(HOLD), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCASE(iCASE), .iMASK(iMASK), .iFORCE(iFORCE),
        .oRESET(oRESET), .oBUSY(oBUSY), .oCAUSE(oCAUSE), .oEVT_CNT(oEVT_CNT)
    );

    always #5 iCLK = ~iCLK;

    // Model: e = clock edges since reset release, p = edge at which the latest pulse began
    int e, p, evts;
    logic [NUM_CH-1:0] shadow, pend, cause;
    bit pendF;
    logic [NUM_CH-1:0] synQ[$];
    int run[NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        e = 0; p = -100000; evts = 0;
        shadow = '0; pend = '0; pendF = 1'b0; cause = '0;
        synQ = {};
        repeat (SYNC) synQ.push_back('0);
        foreach (run[i]) run[i] = 0;
    endtask

    task automatic modelEdge();
        logic [NUM_CH-1:0] syn, diff, chg, upd;
        e++;
        syn = synQ.pop_front();
        synQ.push_back(iCASE);
        diff = (syn ^ shadow) & iMASK;
`ifdef RESET_SEQUENCER_GLITCH_FILTER_EN
        for (int i = 0; i < NUM_CH; i++) begin
            chg[i] = diff[i] && run[i] == FILT;
            run[i] = (diff[i] && !chg[i] && e != POR) ? run[i] + 1 : 0;
        end
`else
        chg = diff;
`endif
        upd = (e == POR) ? '1 : (chg | ~iMASK);
        shadow = (shadow & ~upd) | (syn & upd);
        if (e <= POR) begin
        end else if (e > p + PULSE + HOLD) begin
            if (chg != 0 || iFORCE) begin p = e; cause = chg; evts++; end
        end else if (e < p + PULSE + HOLD) begin
            pend |= chg;
            pendF |= iFORCE;
        end else begin
            if ((pend | chg) != 0 || pendF || iFORCE) begin p = e; cause = pend | chg; evts++; end
            pend = '0;
            pendF = 1'b0;
        end
    endtask

    task automatic compareAll();
        check("oRESET", 32'(oRESET), 32'(e >= POR && !(e >= p && e < p + PULSE)));
        check("oBUSY", 32'(oBUSY), 32'(e < POR || e < p + PULSE + HOLD));
        check("oCAUSE", 32'(oCAUSE), 32'(cause));
        check("oEVT_CNT", 32'(oEVT_CNT), 32'((evts > 255) ? 255 : evts));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            modelEdge();
            @(negedge iCLK);
            compareAll();
        end
    endtask

    task automatic pulseForce();
        iFORCE = 1'b1;
        tick(1);
        iFORCE = 1'b0;
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge iCLK);
        compareAll();
        iRST_N = 1'b1;

        // Power-up with non-zero inputs held from reset
        tick(POR + 20);
        check("t1_evt", 32'(oEVT_CNT), 32'd0);

        // Single channel change
        iCASE[3] = ~iCASE[3];
        tick(10);
        check("t2_cause", 32'(oCAUSE), 32'h008);
        tick(90);

        // Masked change, then unmask
        iMASK[7] = 1'b0;
        iCASE[7] = ~iCASE[7];
        tick(5);
        iMASK[7] = 1'b1;
        tick(100);
        check("t3_evt", 32'(oEVT_CNT), 32'd1);

        // Coalescing of changes during PULSE and HOLDOFF
        iCASE[0] = ~iCASE[0];
        tick(5);
        check("t4_cause1", 32'(oCAUSE), 32'h001);
        iCASE[5] = ~iCASE[5];
        tick(30);
        iCASE[9] = ~iCASE[9];
        tick(150);
        check("t4_cause2", 32'(oCAUSE), 32'h220);

        // Forced pulse aborted by asynchronous reset
        pulseForce();
        tick(8);
        check("t5_cause", 32'(oCAUSE), 32'h000);
        #2 iRST_N = 1'b0;
        #1 modelReset();
        compareAll();
        @(negedge iCLK);
        iRST_N = 1'b1;
        tick(POR + 10);

        // Glitch versus sustained level on channel 2
        iCASE[2] = ~iCASE[2];
        tick(3);
        iCASE[2] = ~iCASE[2];
        tick(100);
        iCASE[2] = ~iCASE[2];
        tick(100);

        // Random changes, masks and forces
        for (int k = 0; k < 150; k++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act < 6) iCASE = iCASE ^ NUM_CH'($urandom & $urandom);
            else if (act < 8) iMASK = (act == 6) ? NUM_CH'($urandom) : '1;
            if (act == 9) pulseForce();
            tick($urandom_range(1, 100));
        end
        iMASK = '1;
        tick(100);

        // Event counter saturation
        for (int k = 0; k < 260; k++) begin
            iCASE[1] = ~iCASE[1];
            tick(90);
        end
        check("t6_evt", 32'(oEVT_CNT), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
